// File: rtl/in_pass4_sync_frame_config_pkg.sv
// Shared definitions for the frame-configured four-channel input pass BEL.
package in_pass4_sync_frame_config_pkg;
    localparam int NUM_LANES    = 4;
    localparam int NoConfigBits = 8;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_REG    = 2'b01;
    localparam logic [1:0] MODE_SYNC2  = 2'b10;
    localparam logic [1:0] MODE_PULSE  = 2'b11;
endpackage

// File: rtl/in_pass4_sync_frame_config_if.sv
// Pad-side inputs, switch-matrix outputs and config bits of the input pass BEL.
interface in_pass4_sync_frame_config_if;
    logic I0, I1, I2, I3;
    logic O0, O1, O2, O3;
    logic [in_pass4_sync_frame_config_pkg::NoConfigBits-1:0] ConfigBits;

    modport master (output I0, I1, I2, I3, ConfigBits, input O0, O1, O2, O3);
    modport slave  (input I0, I1, I2, I3, ConfigBits, output O0, O1, O2, O3);
endinterface

// File: rtl/in_pass4_sync_frame_config_chan.sv
// One input channel: three-flop chain plus a 4:1 mode select built from mux2 cells.
module my_mux2 (
    input  logic A0,
    input  logic A1,
    input  logic S,
    output logic X
);
    assign X = S ? A1 : A0;
endmodule

module in_pass_sync_chan (
    input  logic       UserCLK,
    input  logic       Reset,
    input  logic       I,
    input  logic [1:0] Mode,
    output logic       O
);
    logic s1, s2, s3;
    logic pulse, loSel, hiSel;

    // Flops run in every mode so a mode change only re-selects existing state.
    always_ff @(posedge UserCLK or posedge Reset) begin
        if (Reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= I;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse = s2 & ~s3;

    my_mux2 muxLo  (.A0(I),     .A1(s1),    .S(Mode[0]), .X(loSel));
    my_mux2 muxHi  (.A0(s2),    .A1(pulse), .S(Mode[0]), .X(hiSel));
    my_mux2 muxOut (.A0(loSel), .A1(hiSel), .S(Mode[1]), .X(O));
endmodule

// File: rtl/in_pass4_sync_frame_config.sv
// Four-channel inbound pass BEL: pads I0..I3 to switch matrix O0..O3, per-channel mode select.
module in_pass4_sync_frame_config
    import in_pass4_sync_frame_config_pkg::*;
(
    input  logic                        UserCLK,
    input  logic                        Reset,
    in_pass4_sync_frame_config_if.slave bus
);
    logic [NUM_LANES-1:0] padIn;
    logic [NUM_LANES-1:0] chanOut;

    assign padIn  = {bus.I3, bus.I2, bus.I1, bus.I0};
    assign bus.O0 = chanOut[0];
    assign bus.O1 = chanOut[1];
    assign bus.O2 = chanOut[2];
    assign bus.O3 = chanOut[3];

    // Channel n takes its mode from ConfigBits[2n+1:2n].
    for (genvar n = 0; n < NUM_LANES; n++) begin : gChan
        in_pass_sync_chan uChan (
            .UserCLK (UserCLK),
            .Reset   (Reset),
            .I       (padIn[n]),
            .Mode    (bus.ConfigBits[2*n +: 2]),
            .O       (chanOut[n])
        );
    end
endmodule
